// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } arb_state_t;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD     = 9600;
  localparam int BAUD_DIV = CLK_HZ / BAUD;

  // Never returns less than 1, so the result is always usable as a vector width.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set bit of req_valid at or above rr_ptr, wrapping.
// Purely combinational; no backpressure of its own.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Scan from the farthest offset down so the nearest valid requester wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (req_valid[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; tx_start one cycle after accept.
// req_ready only in IDLE; producers are held off for the whole frame plus guard gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [clog2(N_REQ)-1:0]   grant_id,
  output logic                      frame_done,
  output logic                      err_timeout
);

  localparam int IW       = clog2(N_REQ);
  localparam int TW       = clog2(START_TIMEOUT);
  localparam int GW       = clog2(GAP_CYCLES + 2);
  // Counter starts at 0 the cycle after tx_start, so the pulse lands START_TIMEOUT cycles after it.
  localparam int TO_LAST  = START_TIMEOUT - 2;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam arb_state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

  arb_state_t        state, state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [TW-1:0]     to_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [N_REQ-1:0]  pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] sel_data;
  logic              accept, start_nxt, done_nxt, tmo_nxt, to_clr, to_inc, gap_inc;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
    gap_inc   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = pick_grant;
        if (pick_any) begin
          accept    = 1'b1;
          start_nxt = ~tx_busy;
          state_nxt = START;
        end
      end
      // tx_start is registered, so the busy check is made one cycle ahead of the pulse.
      START: begin
        if (tx_start) begin
          to_clr    = 1'b1;
          state_nxt = WAIT_BUSY;
        end else begin
          start_nxt = ~tx_busy;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TW'(TO_LAST)) begin
          tmo_nxt   = 1'b1;
          state_nxt = AFTER_FRAME;
        end else begin
          to_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_nxt  = 1'b1;
          state_nxt = AFTER_FRAME;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_LAST)) state_nxt = IDLE;
        else gap_inc = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      tx_start    <= start_nxt;
      frame_done  <= done_nxt;
      err_timeout <= tmo_nxt;
      if (accept) begin
        tx_data  <= sel_data;
        grant_id <= pick_idx;
        rr_ptr   <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (to_clr) to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + 1'b1;
      if (state != GAP) gap_cnt <= '0;
      else if (gap_inc) gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a no-gap instance with a transmitter busy model, and a GAP_CYCLES=5 instance.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        frame_done, err_timeout;

  logic [3:0]  g_valid = '0;
  logic [31:0] g_data = '0;
  logic [3:0]  g_ready;
  logic [7:0]  g_tx_data;
  logic        g_tx_start;
  logic        g_busy = 1'b0;
  logic [1:0]  g_grant_id;
  logic        g_frame_done, g_err_timeout;

  logic busy_en = 1'b0, force_busy = 1'b0, model_busy = 1'b0;
  int   busy_len = 4;
  int   checks = 0, errors = 0;
  logic [7:0] order_q[$];

  assign tx_busy = busy_en ? model_busy : force_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .START_TIMEOUT(16), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
    .frame_done(frame_done), .err_timeout(err_timeout)
  );

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .START_TIMEOUT(16), .GAP_CYCLES(5)) dut_g (
    .clk(clk), .reset(reset), .req_valid(g_valid), .req_data(g_data), .req_ready(g_ready),
    .tx_data(g_tx_data), .tx_start(g_tx_start), .tx_busy(g_busy), .grant_id(g_grant_id),
    .frame_done(g_frame_done), .err_timeout(g_err_timeout)
  );

  // Transmitter: busy rises the cycle after a start pulse and stays high busy_len cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (busy_en && tx_start) begin
        @(posedge clk); #1;
        model_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    g_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    checks++; if (frame_done !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b tmo=%b want 0 0", frame_done, err_timeout); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_idle: got %b want 0000", req_ready); end
    checks++; if (g_tx_data !== 8'h00 || g_tx_start !== 1'b0) begin errors++; $display("FAIL reset_gap_inst: got data=%h start=%b want 00 0", g_tx_data, g_tx_start); end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ptr: got %b want 0001", req_ready); end
    req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int n, extra;
    busy_en = 1'b1;
    busy_len = 100;
    do_reset();
    req_data = 32'h33A5_2211;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", tx_data); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    n = -1;
    extra = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (tx_start) extra++;
      if (frame_done) begin n = i; break; end
    end
    checks++; if (n != 102) begin errors++; $display("FAIL single_frame_done: got %0d cycles want 102", n); end
    checks++; if (extra != 0) begin errors++; $display("FAIL single_extra_start: got %0d want 0", extra); end
  endtask

  // Reference: idle once frame_done is due (accept + 3 + busy length), next grant = first valid from pointer.
  task automatic run_model(input int ncyc, input bit all_valid);
    int ptr, acc, next_idle, flen, idx;
    logic [3:0] v, exp_rdy;
    logic [7:0] exp_b;
    logic [1:0] exp_g;
    ptr = 0; acc = -100; next_idle = 0; flen = 0; idx = 0;
    exp_b = '0; exp_g = '0;
    order_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      v = all_valid ? 4'hF : 4'($urandom_range(0, 15));
      req_valid = v;
      req_data = all_valid ? 32'h1312_1110 : $urandom;
      #1;
      exp_rdy = '0;
      if (k >= next_idle) begin
        for (int o = 0; o < N; o++) begin
          if (exp_rdy == '0 && v[(ptr + o) % N]) begin
            idx = (ptr + o) % N;
            exp_rdy[idx] = 1'b1;
          end
        end
      end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL model_ready cyc %0d: got %b want %b", k, req_ready, exp_rdy); end
      checks++; if (tx_start !== (k == acc + 1)) begin errors++; $display("FAIL model_start cyc %0d: got %b want %b", k, tx_start, (k == acc + 1)); end
      checks++; if (frame_done !== (k == acc + 3 + flen)) begin errors++; $display("FAIL model_done cyc %0d: got %b want %b", k, frame_done, (k == acc + 3 + flen)); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL model_tmo cyc %0d: got %b want 0", k, err_timeout); end
      if (k == acc + 1) begin
        checks++; if (tx_data !== exp_b || grant_id !== exp_g) begin errors++; $display("FAIL model_byte cyc %0d: got %h/%0d want %h/%0d", k, tx_data, grant_id, exp_b, exp_g); end
        order_q.push_back(tx_data);
      end
      if (exp_rdy != '0) begin
        exp_b = req_data[idx*W +: W];
        exp_g = 2'(idx);
        ptr = (idx + 1) % N;
        acc = k;
        flen = $urandom_range(1, 8);
        busy_len = flen;
        next_idle = k + 3 + flen;
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_o [5];
    exp_o = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    busy_en = 1'b1;
    do_reset();
    run_model(120, 1'b1);
    checks++; if (order_q.size() < 5) begin errors++; $display("FAIL rr_count: got %0d frames want >=5", order_q.size()); end
    for (int i = 0; i < 5 && i < order_q.size(); i++) begin
      checks++; if (order_q[i] !== exp_o[i]) begin errors++; $display("FAIL rr_order[%0d]: got %h want %h", i, order_q[i], exp_o[i]); end
    end
  endtask

  task automatic test_random();
    busy_en = 1'b1;
    do_reset();
    run_model(600, 1'b0);
  endtask

  task automatic test_timeout();
    int n, fd;
    busy_en = 1'b0;
    force_busy = 1'b0;
    do_reset();
    req_data = 32'h0000_003C;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL tmo_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL tmo_start: got %b want 1", tx_start); end
    n = -1;
    fd = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (frame_done) fd++;
      if (err_timeout) begin n = i; break; end
    end
    checks++; if (n != 16) begin errors++; $display("FAIL tmo_delay: got %0d cycles want 16", n); end
    checks++; if (fd != 0) begin errors++; $display("FAIL tmo_no_done: got %0d frame_done want 0", fd); end
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL tmo_next_ready: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (grant_id !== 2'd1 || tx_start !== 1'b1) begin errors++; $display("FAIL tmo_next_grant: got %0d/%b want 1/1", grant_id, tx_start); end
  endtask

  task automatic test_stale_busy();
    int starts, got;
    busy_en = 1'b0;
    force_busy = 1'b1;
    do_reset();
    req_data = 32'h0000_0042;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stale_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      if (tx_start) starts++;
      @(negedge clk);
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL stale_withheld: got %0d pulses want 0", starts); end
    force_busy = 1'b0;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL stale_early: got %b want 0", tx_start); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h42) begin errors++; $display("FAIL stale_release: got %b/%h want 1/42", tx_start, tx_data); end
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    force_busy = 1'b0;
    got = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (frame_done) begin got = 1; break; end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL stale_done: got %0d want 1", got); end
  endtask

  task automatic test_reset_midframe();
    busy_en = 1'b1;
    busy_len = 50;
    do_reset();
    req_data = 32'h0077_0000;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    req_valid = 4'b1001;
    req_data = 32'h5500_0066;
    @(negedge clk);
    checks++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin errors++; $display("FAIL midrst_regs: got %h/%0d want 00/0", tx_data, grant_id); end
    checks++; if (tx_start !== 1'b0 || frame_done !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got %b%b%b want 000", tx_start, frame_done, err_timeout); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_idle_ptr: got %b want 0001", req_ready); end
    reset = 1'b0;
    @(negedge clk);
    req_valid = '0;
    checks++; if (grant_id !== 2'd0 || tx_data !== 8'h66) begin errors++; $display("FAIL midrst_first: got %0d/%h want 0/66", grant_id, tx_data); end
    busy_en = 1'b0;
  endtask

  task automatic test_guard_gap();
    int got, n;
    do_reset();
    g_data = 32'h0000_BBAA;
    g_valid = 4'b0011;
    #1;
    checks++; if (g_ready !== 4'b0001) begin errors++; $display("FAIL gap_ready0: got %b want 0001", g_ready); end
    @(negedge clk);
    checks++; if (g_tx_start !== 1'b1 || g_tx_data !== 8'hAA) begin errors++; $display("FAIL gap_start: got %b/%h want 1/aa", g_tx_start, g_tx_data); end
    g_busy = 1'b1;
    repeat (3) @(negedge clk);
    g_busy = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (g_frame_done) begin got = 1; break; end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL gap_done: got %0d want 1", got); end
    checks++; if (g_ready !== 4'b0000) begin errors++; $display("FAIL gap_ready_at_done: got %b want 0000", g_ready); end
    n = 0;
    while (g_ready == 4'b0000 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL gap_len: got %0d cycles want 5", n); end
    checks++; if (g_ready !== 4'b0010) begin errors++; $display("FAIL gap_ready1: got %b want 0010", g_ready); end
    g_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_timeout();
    test_stale_busy();
    test_reset_midframe();
    test_guard_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
